// File: rtl/sync_fifo_rr_ctrl.sv
// sync_fifo_rr_ctrl
// FIFO controller for an external single-clock RAM. NUM_REQ write requesters
// share the write port through a round-robin arbiter. A single consumer drains
// the head entry. The RAM read is combinational, so a word written in one
// cycle is visible at the head on the next cycle.
module sync_fifo_rr_ctrl #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 3,
  parameter int NUM_REQ   = 4,
  localparam int DEPTH    = 1 << ADDR_SIZE,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         mem_wen,
  output logic [ADDR_SIZE-1:0]         mem_waddr,
  output logic [DATA_SIZE-1:0]         mem_wdata,
  output logic [ADDR_SIZE-1:0]         mem_raddr,
  input  logic [DATA_SIZE-1:0]         mem_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_SIZE-1:0]         out_data,
  output logic                         full,
  output logic                         empty,
  output logic [ADDR_SIZE:0]           count,
  output logic [ID_W-1:0]              grant_id
);

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  localparam int CNT_W = ADDR_SIZE + 1;

  typedef logic [CNT_W-1:0] ptr_t;
  typedef logic [ID_W-1:0]  id_t;

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  id_t  rr_ptr;
  id_t  grant;
  id_t  next_rr;
  logic any_valid;
  logic wr_acc;
  logic rd_acc;

  // Round-robin search: the first valid requester at or after 'start', wrapping
  // at NUM_REQ. Walking the candidates from the farthest back to the nearest
  // means the nearest valid one is the last assignment made, so it wins.
  function automatic id_t rr_pick(input logic [NUM_REQ-1:0] valid, input id_t start);
    id_t pick;
    int  idx;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (valid[idx]) pick = id_t'(idx);
    end
    return pick;
  endfunction

  assign any_valid = |req_valid;
  assign grant     = rr_pick(req_valid, rr_ptr);
  assign next_rr   = (grant == id_t'(NUM_REQ - 1)) ? '0 : grant + id_t'(1);

  // Occupancy is the modular pointer distance. A distance of DEPTH is exactly
  // the case where the wrap bits differ and the low address bits match.
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (count == ptr_t'(DEPTH));

  // While full, a write is refused even if a read frees a slot in the same
  // cycle. The freed space is seen on the next cycle. Reset blocks all writes.
  assign wr_acc = !rst && !full && any_valid;
  assign rd_acc = !empty && out_ready;

  assign mem_waddr = wr_ptr[ADDR_SIZE-1:0];
  assign mem_raddr = rd_ptr[ADDR_SIZE-1:0];
  assign out_valid = !empty;
  assign out_data  = mem_rdata;

  // Write-side handshake: one-hot ready for the granted requester, RAM write same cycle.
  always_comb begin
    // NOTE: every output gets a default before any branch so the block never infers a latch.
    req_ready = '0;
    grant_id  = '0;
    mem_wen   = 1'b0;
    mem_wdata = req_data[int'(grant) * DATA_SIZE +: DATA_SIZE];
    if (wr_acc) begin
      req_ready[grant] = 1'b1;
      grant_id         = grant;
      mem_wen          = 1'b1;
    end
  end

  // Pointer and round-robin state. Reset takes priority over any accept in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rr_ptr <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
        rr_ptr <= next_rr;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_rr_ctrl.sv
// tb_sync_fifo_rr_ctrl
// Bench for sync_fifo_rr_ctrl, with a behavioural RAM attached.
// The expected grant for each cycle is written as a literal constant.
// Accepted write data is pushed to a scoreboard queue. It is popped and
// compared against out_data when the consumer takes the head entry.
module tb_sync_fifo_rr_ctrl;

  localparam int DATA_SIZE = 32;
  localparam int ADDR_SIZE = 3;
  localparam int NUM_REQ   = 4;
  localparam int DEPTH     = 1 << ADDR_SIZE;
  localparam int ID_W      = $clog2(NUM_REQ);

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         mem_wen;
  logic [ADDR_SIZE-1:0]         mem_waddr;
  logic [DATA_SIZE-1:0]         mem_wdata;
  logic [ADDR_SIZE-1:0]         mem_raddr;
  logic [DATA_SIZE-1:0]         mem_rdata;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_SIZE-1:0]         out_data;
  logic                         full;
  logic                         empty;
  logic [ADDR_SIZE:0]           count;
  logic [ID_W-1:0]              grant_id;

  sync_fifo_rr_ctrl #(
    .DATA_SIZE(DATA_SIZE),
    .ADDR_SIZE(ADDR_SIZE),
    .NUM_REQ  (NUM_REQ)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .mem_wen  (mem_wen),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  // External RAM: synchronous write, combinational read.
  logic [DATA_SIZE-1:0] mem [DEPTH];
  always @(posedge clk) if (mem_wen) mem[mem_waddr] <= mem_wdata;
  assign mem_rdata = mem[mem_raddr];

  int n_checks = 0;
  int n_errors = 0;

  // Bench-side state, advanced only from the literal expectations of each step.
  int                   m_count;
  logic [ADDR_SIZE:0]   m_wr;
  logic [ADDR_SIZE:0]   m_rd;
  logic [DATA_SIZE-1:0] sb [$];

  typedef struct {
    logic [NUM_REQ-1:0] v;
    logic               rdy;
    logic [NUM_REQ-1:0] exp_ready;
  } vec_t;

  vec_t tbl [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Requester i drives base + i*0x100, which keeps every lane distinct.
  function automatic logic [NUM_REQ*DATA_SIZE-1:0] mk_data(input logic [DATA_SIZE-1:0] base);
    logic [NUM_REQ*DATA_SIZE-1:0] r;
    for (int i = 0; i < NUM_REQ; i++) r[i*DATA_SIZE +: DATA_SIZE] = base + DATA_SIZE'(i * 256);
    return r;
  endfunction

  // Each step is one clock: drive at posedge+1, check at negedge, then update the model after the edge.
  task automatic step(input string tag, input logic [NUM_REQ-1:0] v, input logic rdy,
                      input logic [DATA_SIZE-1:0] base, input logic [NUM_REQ-1:0] exp_ready);
    logic [NUM_REQ*DATA_SIZE-1:0] d;
    logic [DATA_SIZE-1:0]         wexp;
    logic [ID_W-1:0]              exp_gid;
    logic                         wacc;
    logic                         racc;
    d         = mk_data(base);
    req_valid = v;
    out_ready = rdy;
    req_data  = d;
    exp_gid   = '0;
    for (int i = 0; i < NUM_REQ; i++) if (exp_ready[i]) exp_gid = ID_W'(i);
    wacc = |exp_ready;
    racc = rdy && (m_count != 0);
    @(negedge clk);
    check({tag, ".count"},     count,     m_count);
    check({tag, ".empty"},     empty,     m_count == 0);
    check({tag, ".full"},      full,      m_count == DEPTH);
    check({tag, ".out_valid"}, out_valid, m_count != 0);
    check({tag, ".req_ready"}, req_ready, exp_ready);
    check({tag, ".grant_id"},  grant_id,  exp_gid);
    check({tag, ".mem_wen"},   mem_wen,   wacc);
    check({tag, ".mem_waddr"}, mem_waddr, m_wr[ADDR_SIZE-1:0]);
    check({tag, ".mem_raddr"}, mem_raddr, m_rd[ADDR_SIZE-1:0]);
    if (wacc) begin
      wexp = d[int'(exp_gid) * DATA_SIZE +: DATA_SIZE];
      check({tag, ".mem_wdata"}, mem_wdata, wexp);
      sb.push_back(wexp);
    end
    if (racc && sb.size() > 0) check({tag, ".out_data"}, out_data, sb.pop_front());
    @(posedge clk);
    #1;
    m_count = m_count + int'(wacc) - int'(racc);
    if (wacc) m_wr = m_wr + 1'b1;
    if (racc) m_rd = m_rd + 1'b1;
  endtask

  // One reset cycle with every requester and the consumer active; nothing may be accepted.
  task automatic do_reset(input string tag);
    rst       = 1'b1;
    req_valid = '1;
    out_ready = 1'b1;
    req_data  = mk_data(32'hDEAD_0000);
    @(negedge clk);
    check({tag, ".rst_req_ready"}, req_ready, 0);
    check({tag, ".rst_mem_wen"},   mem_wen,   0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    m_count   = 0;
    m_wr      = '0;
    m_rd      = '0;
    sb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t reached, expected finish well before", $time);
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    req_data  = '0;
    m_count   = 0;
    m_wr      = '0;
    m_rd      = '0;

    // All four requesters valid, consumer idle: grants go 0,1,2,3 twice, then the FIFO is full.
    tbl.push_back('{4'b1111, 1'b0, 4'b0001});
    tbl.push_back('{4'b1111, 1'b0, 4'b0010});
    tbl.push_back('{4'b1111, 1'b0, 4'b0100});
    tbl.push_back('{4'b1111, 1'b0, 4'b1000});
    tbl.push_back('{4'b1111, 1'b0, 4'b0001});
    tbl.push_back('{4'b1111, 1'b0, 4'b0010});
    tbl.push_back('{4'b1111, 1'b0, 4'b0100});
    tbl.push_back('{4'b1111, 1'b0, 4'b1000});
    tbl.push_back('{4'b1111, 1'b0, 4'b0000});
    tbl.push_back('{4'b1111, 1'b0, 4'b0000});
    for (int k = 0; k < 8; k++) tbl.push_back('{4'b0000, 1'b1, 4'b0000});
    // Sparse request patterns with rr_ptr starting at 0.
    tbl.push_back('{4'b1010, 1'b0, 4'b0010});
    tbl.push_back('{4'b1010, 1'b0, 4'b1000});
    tbl.push_back('{4'b0100, 1'b1, 4'b0100});
    tbl.push_back('{4'b0001, 1'b1, 4'b0001});
    tbl.push_back('{4'b1001, 1'b0, 4'b1000});
    tbl.push_back('{4'b1001, 1'b0, 4'b0001});
    // Drain four entries, then one extra out_ready while empty (must be ignored).
    for (int k = 0; k < 5; k++) tbl.push_back('{4'b0000, 1'b1, 4'b0000});

    repeat (2) @(posedge clk);
    #1;
    do_reset("init");
    for (int k = 0; k < tbl.size(); k++)
      step($sformatf("vec%0d", k), tbl[k].v, tbl[k].rdy,
           DATA_SIZE'(32'h1000_0000 + (k << 16)), tbl[k].exp_ready);

    // A single requester fills the FIFO with 0xA0..0xA7. The 9th word is held off.
    // The reads then return the words in order.
    do_reset("fill");
    for (int k = 0; k < 8; k++)
      step($sformatf("fill_w%0d", k), 4'b0001, 1'b0, DATA_SIZE'(32'hA0 + k), 4'b0001);
    step("fill_ninth", 4'b0001, 1'b0, 32'hA8, 4'b0000);
    for (int k = 0; k < 8; k++)
      step($sformatf("fill_r%0d", k), 4'b0000, 1'b1, 32'h0, 4'b0000);
    step("fill_empty", 4'b0000, 1'b0, 32'h0, 4'b0000);

    // Full with a read and a write in the same cycle: the read goes, the write is refused.
    // On the next cycle the write goes in.
    do_reset("fullrw");
    for (int k = 0; k < 8; k++)
      step($sformatf("fullrw_w%0d", k), 4'b0010, 1'b0, DATA_SIZE'(32'hB000 + k), 4'b0010);
    step("fullrw_both",  4'b0010, 1'b1, 32'hB100, 4'b0000);
    step("fullrw_retry", 4'b0010, 1'b0, 32'hB200, 4'b0010);
    step("fullrw_hold",  4'b0000, 1'b0, 32'h0,    4'b0000);
    for (int k = 0; k < 8; k++)
      step($sformatf("fullrw_r%0d", k), 4'b0000, 1'b1, 32'h0, 4'b0000);

    // Count held at 3 for 20 simultaneous read/write cycles. The pointers wrap past 15.
    do_reset("stream");
    for (int k = 0; k < 3; k++)
      step($sformatf("stream_pre%0d", k), 4'b0001, 1'b0, DATA_SIZE'(32'hC000 + k), 4'b0001);
    for (int k = 0; k < 20; k++)
      step($sformatf("stream_rw%0d", k), 4'b0001, 1'b1, DATA_SIZE'(32'hC100 + k), 4'b0001);
    for (int k = 0; k < 3; k++)
      step($sformatf("stream_post%0d", k), 4'b0000, 1'b1, 32'h0, 4'b0000);

    // Write 0x55 into an empty FIFO. It is at the head on the next cycle.
    // rr_ptr is 1 here, so the search 1,2,3,0 lands on requester 0.
    step("lat_write", 4'b0001, 1'b0, 32'h55, 4'b0001);
    step("lat_read",  4'b0000, 1'b1, 32'h0,  4'b0000);

    // Reset with count=5 and rr_ptr=2. The first grant afterwards goes to requester 0.
    for (int k = 0; k < 4; k++)
      step($sformatf("mid_w%0d", k), 4'b0001, 1'b0, DATA_SIZE'(32'hD000 + k), 4'b0001);
    step("mid_w4",   4'b0010, 1'b0, 32'hD010, 4'b0010);
    step("mid_hold", 4'b0000, 1'b0, 32'h0,    4'b0000);
    do_reset("mid");
    step("mid_after", 4'b1111, 1'b0, 32'hE000, 4'b0001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_rr_ctrl.md
SYNC_FIFO_RR_CTRL -- requirements
Module: sync_fifo_rr_ctrl

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, memory word width.
REQ-002 SHALL have parameter ADDR_SIZE, default 3, memory address width.
REQ-003 SHALL have parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-004 SHALL have derived parameter DEPTH = 1 << ADDR_SIZE, FIFO capacity.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  NUM_REQ  per-requester write request.
REQ-008 SHALL have port req_data  input  NUM_REQ*DATA_SIZE  requester i data at bits [i*DATA_SIZE +: DATA_SIZE].
REQ-009 SHALL have port req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-010 SHALL have port mem_wen  output  1  memory write enable.
REQ-011 SHALL have port mem_waddr  output  ADDR_SIZE  memory write address.
REQ-012 SHALL have port mem_wdata  output  DATA_SIZE  memory write data.
REQ-013 SHALL have port mem_raddr  output  ADDR_SIZE  memory read address.
REQ-014 SHALL have port mem_rdata  input  DATA_SIZE  combinational memory read data for mem_raddr.
REQ-015 SHALL have port out_valid  output  1  head entry available.
REQ-016 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-017 SHALL have port out_data  output  DATA_SIZE  head entry, equal to mem_rdata.
REQ-018 SHALL have ports full, empty  output  1 each; and count  output  ADDR_SIZE+1  occupancy.
REQ-019 SHALL have port grant_id  output  $clog2(NUM_REQ)  index of granted requester (0 when none).

Function
REQ-020 SHALL keep wr_ptr, rd_ptr of ADDR_SIZE+1 bits; mem_waddr = wr_ptr[ADDR_SIZE-1:0], mem_raddr = rd_ptr[ADDR_SIZE-1:0].
REQ-021 SHALL derive empty = (wr_ptr == rd_ptr); full = (MSBs differ, low bits equal); count = wr_ptr - rd_ptr modulo 2^(ADDR_SIZE+1).
REQ-022 SHALL keep round-robin pointer rr_ptr (requester index); grant = first i with req_valid[i]=1 searching rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ.
REQ-023 SHALL assert req_ready[grant] combinationally only when !full and some req_valid is set; all other req_ready bits 0.
REQ-024 SHALL treat write accept = req_valid[g] & req_ready[g]; on accept mem_wen=1, mem_wdata = req_data of g, same cycle.
REQ-025 SHALL advance wr_ptr by 1 and set rr_ptr = (g+1) mod NUM_REQ at the clock edge of each accept; rr_ptr unchanged otherwise.
REQ-026 SHALL hold mem_wen=0 when no accept; mem_wdata value then don't-care but mem_wen SHALL never pulse while full.
REQ-027 SHALL assert out_valid = !empty; read accept = out_valid & out_ready advances rd_ptr by 1; out_ready while empty ignored.
REQ-028 SHALL allow simultaneous write and read accept in one cycle: both pointers advance, count unchanged.
REQ-029 SHALL, when full, refuse writes even if a read accepts same cycle; write space visible next cycle.
REQ-030 SHALL, on write into empty FIFO, assert out_valid the next cycle (one-cycle write-to-read latency) with out_data = written word.
REQ-031 SHALL wrap pointers naturally mod 2^(ADDR_SIZE+1); no overflow or underflow possible.
REQ-032 SHALL be fairness-bounded: a continuously valid requester is granted within NUM_REQ accepts.

Reset
REQ-033 SHALL on rst=1 at clk edge set wr_ptr=0, rd_ptr=0, rr_ptr=0, giving empty=1, full=0, count=0, out_valid=0, mem_wen=0, req_ready=0.
REQ-034 SHALL during rst=1 suppress accepts (req_ready=0, mem_wen=0); reset mid-operation discards all stored entries.

Verification
REQ-035 Single requester 0 writes 0xA0..0xA7 (DEPTH=8) -> full=1, count=8, req_ready=0; 9th held; reads return 0xA0..0xA7 in order, then empty=1.
REQ-036 All 4 req_valid held high, consumer idle -> grant order 0,1,2,3,0,1,2,3 until full, then req_ready=0.
REQ-037 Count=8, out_ready=1 and req_valid[1]=1 same cycle -> read accepted, write refused; next cycle write accepted, count stays 8.
REQ-038 Count=3, simultaneous write and read for 20 cycles -> count=3 throughout, pointers wrap past 15 to 0, data order preserved.
REQ-039 Write 0x55 into empty FIFO at cycle N -> out_valid=1, out_data=0x55 at cycle N+1.
REQ-040 Assert rst with count=5 and rr_ptr=2 -> next cycle empty=1, count=0, first grant under all-valid goes to requester 0.
